// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one combinational ALU between two requesters.
// The granted operation's result and flags land in a single registered
// response slot that holds until the consumer takes it.
module alu_arbiter #(
  parameter int unsigned width = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [width-1:0] req0_a,
  input  logic [width-1:0] req0_b,
  input  logic [1:0]       req0_ctrl,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [width-1:0] req1_a,
  input  logic [width-1:0] req1_b,
  input  logic [1:0]       req1_ctrl,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic             rsp_id,
  output logic [width-1:0] rsp_result,
  output logic [3:0]       rsp_flags
);

  typedef enum logic {StEmpty, StFull} slot_state_e;

  slot_state_e      state_q, state_d;
  logic [width-1:0] result_q, result_d;
  logic [3:0]       flags_q, flags_d;
  logic             id_q, id_d;
  logic             last_grant_q, last_grant_d;

  logic             slot_free, grant, accept;
  logic [width-1:0] alu_a, alu_b, alu_result;
  logic [1:0]       alu_ctrl;
  logic [width:0]   sum_ext;
  logic             alu_c, alu_v;
  logic [3:0]       alu_flags;

  // Arbitration: single requester wins outright, a tie goes to the one not served last.
  always_comb begin
    grant = 1'b0;
    if (req0_valid && req1_valid) begin
      grant = ~last_grant_q;
    end else if (req1_valid) begin
      grant = 1'b1;
    end
    slot_free  = (state_q == StEmpty) || rsp_ready;
    // Readies are held low while reset is asserted, not just after it.
    accept     = !reset && slot_free && (req0_valid || req1_valid);
    req0_ready = accept && !grant;
    req1_ready = accept && grant;
  end

  // Operand mux in front of the shared ALU.
  always_comb begin
    alu_a    = grant ? req1_a    : req0_a;
    alu_b    = grant ? req1_b    : req0_b;
    alu_ctrl = grant ? req1_ctrl : req0_ctrl;
  end

  // Shared combinational ALU; SUB is A + ~B + 1 so carry-out means no borrow.
  always_comb begin
    sum_ext    = '0;
    alu_result = '0;
    alu_c      = 1'b0;
    alu_v      = 1'b0;
    unique case (alu_ctrl)
      2'b00: begin
        sum_ext    = {1'b0, alu_a} + {1'b0, alu_b};
        alu_result = sum_ext[width-1:0];
        alu_c      = sum_ext[width];
        alu_v      = (alu_a[width-1] == alu_b[width-1]) &&
                     (alu_result[width-1] != alu_a[width-1]);
      end
      2'b01: begin
        sum_ext    = {1'b0, alu_a} + {1'b0, ~alu_b} + {{width{1'b0}}, 1'b1};
        alu_result = sum_ext[width-1:0];
        alu_c      = sum_ext[width];
        alu_v      = (alu_a[width-1] != alu_b[width-1]) &&
                     (alu_result[width-1] != alu_a[width-1]);
      end
      2'b10: alu_result = alu_a & alu_b;
      2'b11: alu_result = alu_a | alu_b;
    endcase
    alu_flags = {alu_v, alu_c, alu_result[width-1], alu_result == '0};
  end

  // Slot FSM next state: load on accept, empty on drain, otherwise hold.
  always_comb begin
    state_d      = state_q;
    result_d     = result_q;
    flags_d      = flags_q;
    id_d         = id_q;
    last_grant_d = last_grant_q;
    unique case (state_q)
      StEmpty: begin
        if (accept) state_d = StFull;
      end
      StFull: begin
        if (!accept && rsp_ready) state_d = StEmpty;
      end
    endcase
    if (accept) begin
      result_d     = alu_result;
      flags_d      = alu_flags;
      id_d         = grant;
      last_grant_d = grant;
    end
  end

  // State registers; last_grant resets to 1 so req0 wins the first tie.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= StEmpty;
      result_q     <= '0;
      flags_q      <= '0;
      id_q         <= 1'b0;
      last_grant_q <= 1'b1;
    end else begin
      state_q      <= state_d;
      result_q     <= result_d;
      flags_q      <= flags_d;
      id_q         <= id_d;
      last_grant_q <= last_grant_d;
    end
  end

  assign rsp_valid  = (state_q == StFull);
  assign rsp_id     = id_q;
  assign rsp_result = result_q;
  assign rsp_flags  = flags_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Randomised bench for alu_arbiter against a transaction-level reference model.
module tb_alu_arbiter;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         reset;
  logic         v0, v1, rr;
  logic         r0, r1;
  logic [W-1:0] a0, b0, a1, b1;
  logic [1:0]   c0, c1;
  logic         rsp_valid, rsp_id;
  logic [W-1:0] rsp_result;
  logic [3:0]   rsp_flags;

  int checks = 0;
  int errors = 0;

  // Reference model state
  logic         m_valid, m_id, m_last;
  logic [W-1:0] m_result;
  logic [3:0]   m_flags;

  always #5 clk = ~clk;

  alu_arbiter #(.width(W)) dut (
    .clk        (clk),
    .reset      (reset),
    .req0_valid (v0),
    .req0_ready (r0),
    .req0_a     (a0),
    .req0_b     (b0),
    .req0_ctrl  (c0),
    .req1_valid (v1),
    .req1_ready (r1),
    .req1_a     (a1),
    .req1_b     (b1),
    .req1_ctrl  (c1),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rr),
    .rsp_id     (rsp_id),
    .rsp_result (rsp_result),
    .rsp_flags  (rsp_flags)
  );

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // Arithmetic reference: flags {V,C,N,Z} from wide signed/unsigned math.
  function automatic logic [W+3:0] ref_alu(input logic [W-1:0] a, input logic [W-1:0] b,
                                           input logic [1:0] op);
    longint ua = longint'(a);
    longint ub = longint'(b);
    longint sa = longint'($signed(a));
    longint sb = longint'($signed(b));
    longint s;
    logic [W-1:0] r;
    logic c, v;
    c = 1'b0;
    v = 1'b0;
    case (op)
      2'd0: begin
        r = a + b;
        c = (ua + ub) > 64'hFFFF_FFFF;
        s = sa + sb;
        v = (s > 64'sd2147483647) || (s < -64'sd2147483648);
      end
      2'd1: begin
        r = a - b;
        c = ua >= ub;
        s = sa - sb;
        v = (s > 64'sd2147483647) || (s < -64'sd2147483648);
      end
      2'd2: r = a & b;
      default: r = a | b;
    endcase
    return {v, c, r[W-1], r == 0, r};
  endfunction

  task automatic model_reset();
    m_valid  = 1'b0;
    m_id     = 1'b0;
    m_last   = 1'b1;
    m_result = '0;
    m_flags  = '0;
  endtask

  // One cycle: inputs already driven just after a negedge. Returns at the next negedge.
  task automatic step(output logic acc0, output logic acc1);
    logic free, g_any, g;
    logic [W+3:0] res;
    #1;
    free  = !m_valid || rr;
    g_any = free && (v0 || v1);
    g     = (v0 && v1) ? !m_last : v1;
    acc0  = g_any && !g;
    acc1  = g_any && g;
    check_eq("req0_ready", r0, acc0);
    check_eq("req1_ready", r1, acc1);
    @(posedge clk);
    if (g_any) begin
      res      = g ? ref_alu(a1, b1, c1) : ref_alu(a0, b0, c0);
      m_result = res[W-1:0];
      m_flags  = res[W+3:W];
      m_id     = g;
      m_last   = g;
      m_valid  = 1'b1;
    end else if (m_valid && rr) begin
      m_valid = 1'b0;
    end
    @(negedge clk);
    check_eq("rsp_valid", rsp_valid, m_valid);
    check_eq("rsp_id", rsp_id, m_id);
    check_eq("rsp_result", rsp_result, m_result);
    check_eq("rsp_flags", rsp_flags, m_flags);
  endtask

  task automatic set_req(input int n, input logic v, input logic [W-1:0] a,
                         input logic [W-1:0] b, input logic [1:0] c);
    if (n == 0) begin
      v0 = v; a0 = a; b0 = b; c0 = c;
    end else begin
      v1 = v; a1 = a; b1 = b; c1 = c;
    end
  endtask

  function automatic logic [W-1:0] rand_operand();
    case ($urandom_range(0, 5))
      0: return '0;
      1: return 32'h7FFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'hFFFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  logic acc0, acc1;
  logic prev_id;

  initial begin
    reset = 1'b1;
    rr    = 1'b1;
    set_req(0, 1'b1, '0, '0, 2'd0);
    set_req(1, 1'b1, '0, '0, 2'd0);
    model_reset();
    @(negedge clk);
    check_eq("reset_valid", rsp_valid, 1'b0);
    check_eq("reset_result", rsp_result, '0);
    check_eq("reset_ready0", r0, 1'b0);
    check_eq("reset_ready1", r1, 1'b0);
    reset = 1'b0;

    // ADD 5+3 from requester 0
    set_req(0, 1'b1, 32'd5, 32'd3, 2'd0);
    set_req(1, 1'b0, '0, '0, 2'd0);
    step(acc0, acc1);
    check_eq("add_result", rsp_result, 32'd8);
    check_eq("add_flags", rsp_flags, 4'b0000);

    // SUB from requester 1: borrow case, then zero case
    set_req(0, 1'b0, '0, '0, 2'd0);
    set_req(1, 1'b1, 32'd3, 32'd5, 2'd1);
    step(acc0, acc1);
    check_eq("sub_neg_result", rsp_result, 32'hFFFF_FFFE);
    check_eq("sub_neg_flags", rsp_flags, 4'b0010);
    set_req(1, 1'b1, 32'd5, 32'd5, 2'd1);
    step(acc0, acc1);
    check_eq("sub_zero_result", rsp_result, 32'd0);
    check_eq("sub_zero_flags", rsp_flags, 4'b0101);

    // Signed overflow ADD and an AND
    set_req(1, 1'b0, '0, '0, 2'd0);
    set_req(0, 1'b1, 32'h7FFF_FFFF, 32'd1, 2'd0);
    step(acc0, acc1);
    check_eq("ovf_result", rsp_result, 32'h8000_0000);
    check_eq("ovf_flags", rsp_flags, 4'b1010);
    set_req(0, 1'b1, 32'hF0F0, 32'h0FF0, 2'd2);
    step(acc0, acc1);
    check_eq("and_result", rsp_result, 32'h00F0);
    check_eq("and_flags", rsp_flags, 4'b0000);

    // Both valid every cycle: ids must alternate with no idle cycle
    set_req(0, 1'b1, 32'd10, 32'd1, 2'd0);
    set_req(1, 1'b1, 32'd20, 32'd2, 2'd0);
    prev_id = rsp_id;
    for (int i = 0; i < 4; i++) begin
      step(acc0, acc1);
      check_eq("alt_valid", rsp_valid, 1'b1);
      check_eq("alt_id", rsp_id, !prev_id);
      prev_id = rsp_id;
    end

    // Backpressure three cycles, then drain and accept together
    rr = 1'b0;
    for (int i = 0; i < 3; i++) step(acc0, acc1);
    rr = 1'b1;
    step(acc0, acc1);
    check_eq("drain_accept", acc0 || acc1, 1'b1);

    // Reset in the middle of a cycle while the slot is full
    #2;
    reset = 1'b1;
    model_reset();
    #1;
    check_eq("midreset_valid", rsp_valid, 1'b0);
    check_eq("midreset_ready", {r0, r1}, 2'b00);
    @(negedge clk);
    reset = 1'b0;
    step(acc0, acc1);
    check_eq("first_tie_id", rsp_id, 1'b0);

    // Randomised traffic: operands hold while a request waits
    for (int i = 0; i < 400; i++) begin
      rr = ($urandom_range(0, 3) != 0);
      step(acc0, acc1);
      if (acc0 || !v0) begin
        if ($urandom_range(0, 1) == 1)
          set_req(0, 1'b1, rand_operand(), rand_operand(), 2'($urandom_range(0, 3)));
        else
          v0 = 1'b0;
      end
      if (acc1 || !v1) begin
        if ($urandom_range(0, 1) == 1)
          set_req(1, 1'b1, rand_operand(), rand_operand(), 2'($urandom_range(0, 3)));
        else
          v1 = 1'b0;
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
